// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the pipeline control slice.
//   result_src_t : writeback result select (ALU, memory, PC+4)
//   alu_ctrl_t   : ALU operation codes carried through the E stage
//   fwd_sel_t    : operand forward-select codes driven to the E-stage muxes
//   ctrl_t       : decode control bundle held in the D->E register
//   CtrlBubble   : all-zero control bundle loaded for a bubble
package riscv_ctrl_pkg;

  typedef enum logic [1:0] {
    ResultAlu = 2'b00,
    ResultMem = 2'b01,
    ResultPc4 = 2'b10
  } result_src_t;

  typedef enum logic [2:0] {
    AluAdd = 3'b000,
    AluSub = 3'b001,
    AluAnd = 3'b010,
    AluOr  = 3'b011,
    AluSlt = 3'b101
  } alu_ctrl_t;

  typedef enum logic [1:0] {
    FwdNone = 2'b00,
    FwdWb   = 2'b01,
    FwdMem  = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       alu_src;
    logic [1:0] result_src;
    logic [2:0] alu_control;
  } ctrl_t;

  localparam ctrl_t CtrlBubble = '0;

endpackage

// File: rtl/hazard_unit.sv
// Combinational hazard logic: operand forwarding, load-use detection and
// branch/jump redirect.
//   rs1_d_i/rs2_d_i   : decode-stage source registers (load-use compare)
//   rs1_e_i/rs2_e_i   : execute-stage source registers (forward compare)
//   rd_e_i, result_src_e_i          : execute-stage destination / result select
//   rd_m_i, reg_write_m_i           : memory-stage writer
//   rd_w_i, reg_write_w_i           : writeback-stage writer
//   branch_e_i, jump_e_i, zero_e_i  : redirect inputs
//   forward_a_e_o/forward_b_e_o     : forward selects for rs1_e/rs2_e
//   lw_stall_o, pc_src_e_o          : load-use hazard and redirect
module hazard_unit
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs1_d_i,
  input  logic [REG_ADDR_W-1:0] rs2_d_i,
  input  logic [REG_ADDR_W-1:0] rs1_e_i,
  input  logic [REG_ADDR_W-1:0] rs2_e_i,
  input  logic [REG_ADDR_W-1:0] rd_e_i,
  input  logic [1:0]            result_src_e_i,
  input  logic [REG_ADDR_W-1:0] rd_m_i,
  input  logic                  reg_write_m_i,
  input  logic [REG_ADDR_W-1:0] rd_w_i,
  input  logic                  reg_write_w_i,
  input  logic                  branch_e_i,
  input  logic                  jump_e_i,
  input  logic                  zero_e_i,
  output logic [1:0]            forward_a_e_o,
  output logic [1:0]            forward_b_e_o,
  output logic                  lw_stall_o,
  output logic                  pc_src_e_o
);

  // M-stage producer is younger than W, so it is checked first and wins.
  // x0 is never forwarded.
  function automatic fwd_sel_t fwd_sel(input logic [REG_ADDR_W-1:0] rs);
    if (reg_write_m_i && (rd_m_i != '0) && (rd_m_i == rs)) begin
      return FwdMem;
    end else if (reg_write_w_i && (rd_w_i != '0) && (rd_w_i == rs)) begin
      return FwdWb;
    end
    return FwdNone;
  endfunction

  always_comb begin
    forward_a_e_o = fwd_sel(rs1_e_i);
    forward_b_e_o = fwd_sel(rs2_e_i);
    lw_stall_o    = (result_src_e_i == ResultMem) && (rd_e_i != '0) &&
                    ((rs1_d_i == rd_e_i) || (rs2_d_i == rd_e_i));
    pc_src_e_o    = (branch_e_i && zero_e_i) || jump_e_i;
  end

endmodule

// File: rtl/pipeline_control.sv
// Control-path pipeline registers (D->E, E->M, M->W) with hazard handling
// and stall/flush event counters.
//   clk, reset            : rising-edge clock, synchronous active-high reset
//   *_d                   : decode-stage controls and register indices
//   zero_e                : ALU zero flag from the execute stage
//   *_e / *_m / *_w       : stage control outputs
//   forward_a_e/forward_b_e : forward selects for rs1/rs2 in E
//   stall_f, stall_d, flush_d : fetch/decode stall and decode flush
//   stall_cnt, flush_cnt  : saturating counts of stall_d / flush_d cycles
module pipeline_control
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reg_write_d,
  input  logic                  mem_write_d,
  input  logic                  branch_d,
  input  logic                  jump_d,
  input  logic                  alu_src_d,
  input  logic [1:0]            result_src_d,
  input  logic [2:0]            alu_control_d,
  input  logic [REG_ADDR_W-1:0] rs1_d,
  input  logic [REG_ADDR_W-1:0] rs2_d,
  input  logic [REG_ADDR_W-1:0] rd_d,
  input  logic                  zero_e,
  output logic [2:0]            alu_control_e,
  output logic                  alu_src_e,
  output logic [1:0]            forward_a_e,
  output logic [1:0]            forward_b_e,
  output logic                  pc_src_e,
  output logic [REG_ADDR_W-1:0] rd_e,
  output logic                  mem_write_m,
  output logic [REG_ADDR_W-1:0] rd_m,
  output logic                  reg_write_w,
  output logic [1:0]            result_src_w,
  output logic [REG_ADDR_W-1:0] rd_w,
  output logic                  stall_f,
  output logic                  stall_d,
  output logic                  flush_d,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  // D->E
  ctrl_t                 e_ctrl_q, e_ctrl_d;
  logic [REG_ADDR_W-1:0] rs1_e_q, rs1_e_d;
  logic [REG_ADDR_W-1:0] rs2_e_q, rs2_e_d;
  logic [REG_ADDR_W-1:0] rd_e_q, rd_e_d;
  // E->M
  logic                  reg_write_m_q, mem_write_m_q;
  logic [1:0]            result_src_m_q;
  logic [REG_ADDR_W-1:0] rd_m_q;
  // M->W
  logic                  reg_write_w_q;
  logic [1:0]            result_src_w_q;
  logic [REG_ADDR_W-1:0] rd_w_q;
  // Counters
  logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]      flush_cnt_q, flush_cnt_d;

  logic lw_stall;
  logic pc_src;

  hazard_unit #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_hazard_unit (
    .rs1_d_i       (rs1_d),
    .rs2_d_i       (rs2_d),
    .rs1_e_i       (rs1_e_q),
    .rs2_e_i       (rs2_e_q),
    .rd_e_i        (rd_e_q),
    .result_src_e_i(e_ctrl_q.result_src),
    .rd_m_i        (rd_m_q),
    .reg_write_m_i (reg_write_m_q),
    .rd_w_i        (rd_w_q),
    .reg_write_w_i (reg_write_w_q),
    .branch_e_i    (e_ctrl_q.branch),
    .jump_e_i      (e_ctrl_q.jump),
    .zero_e_i      (zero_e),
    .forward_a_e_o (forward_a_e),
    .forward_b_e_o (forward_b_e),
    .lw_stall_o    (lw_stall),
    .pc_src_e_o    (pc_src)
  );

  always_comb begin
    // A redirect overrides the load-use stall so fetch can load the target.
    stall_f = lw_stall && !pc_src;
    stall_d = lw_stall && !pc_src;
    flush_d = pc_src;

    // Bubble on either hazard; decode inputs otherwise pass through untouched.
    if (lw_stall || pc_src) begin
      e_ctrl_d = CtrlBubble;
      rs1_e_d  = '0;
      rs2_e_d  = '0;
      rd_e_d   = '0;
    end else begin
      e_ctrl_d = '{reg_write:   reg_write_d,
                   mem_write:   mem_write_d,
                   branch:      branch_d,
                   jump:        jump_d,
                   alu_src:     alu_src_d,
                   result_src:  result_src_d,
                   alu_control: alu_control_d};
      rs1_e_d  = rs1_d;
      rs2_e_d  = rs2_d;
      rd_e_d   = rd_d;
    end

    stall_cnt_d = stall_cnt_q;
    if (stall_d && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    flush_cnt_d = flush_cnt_q;
    if (flush_d && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_ctrl_q       <= CtrlBubble;
      rs1_e_q        <= '0;
      rs2_e_q        <= '0;
      rd_e_q         <= '0;
      reg_write_m_q  <= 1'b0;
      mem_write_m_q  <= 1'b0;
      result_src_m_q <= '0;
      rd_m_q         <= '0;
      reg_write_w_q  <= 1'b0;
      result_src_w_q <= '0;
      rd_w_q         <= '0;
      stall_cnt_q    <= '0;
      flush_cnt_q    <= '0;
    end else begin
      e_ctrl_q       <= e_ctrl_d;
      rs1_e_q        <= rs1_e_d;
      rs2_e_q        <= rs2_e_d;
      rd_e_q         <= rd_e_d;
      reg_write_m_q  <= e_ctrl_q.reg_write;
      mem_write_m_q  <= e_ctrl_q.mem_write;
      result_src_m_q <= e_ctrl_q.result_src;
      rd_m_q         <= rd_e_q;
      reg_write_w_q  <= reg_write_m_q;
      result_src_w_q <= result_src_m_q;
      rd_w_q         <= rd_m_q;
      stall_cnt_q    <= stall_cnt_d;
      flush_cnt_q    <= flush_cnt_d;
    end
  end

  assign alu_control_e = e_ctrl_q.alu_control;
  assign alu_src_e     = e_ctrl_q.alu_src;
  assign pc_src_e      = pc_src;
  assign rd_e          = rd_e_q;
  assign mem_write_m   = mem_write_m_q;
  assign rd_m          = rd_m_q;
  assign reg_write_w   = reg_write_w_q;
  assign result_src_w  = result_src_w_q;
  assign rd_w          = rd_w_q;
  assign stall_cnt     = stall_cnt_q;
  assign flush_cnt     = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_control.sv
module tb_pipeline_control;

  localparam int unsigned AW = 5;
  localparam int unsigned CW = 4;  // small so saturation is reachable
  localparam int CntMax = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          reg_write_d, mem_write_d, branch_d, jump_d, alu_src_d;
  logic [1:0]    result_src_d;
  logic [2:0]    alu_control_d;
  logic [AW-1:0] rs1_d, rs2_d, rd_d;
  logic          zero_e;
  logic [2:0]    alu_control_e;
  logic          alu_src_e;
  logic [1:0]    forward_a_e, forward_b_e;
  logic          pc_src_e;
  logic [AW-1:0] rd_e, rd_m, rd_w;
  logic          mem_write_m, reg_write_w;
  logic [1:0]    result_src_w;
  logic          stall_f, stall_d, flush_d;
  logic [CW-1:0] stall_cnt, flush_cnt;

  pipeline_control #(
    .REG_ADDR_W(AW),
    .CNT_W     (CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .reg_write_d  (reg_write_d),
    .mem_write_d  (mem_write_d),
    .branch_d     (branch_d),
    .jump_d       (jump_d),
    .alu_src_d    (alu_src_d),
    .result_src_d (result_src_d),
    .alu_control_d(alu_control_d),
    .rs1_d        (rs1_d),
    .rs2_d        (rs2_d),
    .rd_d         (rd_d),
    .zero_e       (zero_e),
    .alu_control_e(alu_control_e),
    .alu_src_e    (alu_src_e),
    .forward_a_e  (forward_a_e),
    .forward_b_e  (forward_b_e),
    .pc_src_e     (pc_src_e),
    .rd_e         (rd_e),
    .mem_write_m  (mem_write_m),
    .rd_m         (rd_m),
    .reg_write_w  (reg_write_w),
    .result_src_w (result_src_w),
    .rd_w         (rd_w),
    .stall_f      (stall_f),
    .stall_d      (stall_d),
    .flush_d      (flush_d),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  always #5 clk = ~clk;

  // One instruction's worth of decode controls.
  typedef struct {
    int rw, mw, br, jp, as, rs, ac, rs1, rs2, rd;
  } instr_t;

  typedef struct {
    int alu_control_e, alu_src_e, fa, fb, pc_src, rd_e, mem_write_m, rd_m;
    int reg_write_w, result_src_w, rd_w, stall_f, stall_d, flush_d, scnt, fcnt;
  } exp_t;

  exp_t   exp_q[$];
  instr_t nop_i = '{default: 0};
  // Instructions currently sitting in E, M and W.
  instr_t in_e, in_m, in_w;
  int     m_scnt, m_fcnt;
  bit     last_stall;
  int     checks = 0;
  int     errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Which older instruction supplies a source register: 2=M, 1=W, 0=none.
  function automatic int producer(input int rs);
    if (in_m.rw != 0 && in_m.rd != 0 && in_m.rd == rs) return 2;
    if (in_w.rw != 0 && in_w.rd != 0 && in_w.rd == rs) return 1;
    return 0;
  endfunction

  // Apply inputs for this cycle, push the expected outputs, advance the model.
  task automatic drive(input instr_t d, input int z, input int r);
    exp_t e;
    int   redirect, load_use, stall;
    reg_write_d   = d.rw[0];
    mem_write_d   = d.mw[0];
    branch_d      = d.br[0];
    jump_d        = d.jp[0];
    alu_src_d     = d.as[0];
    result_src_d  = d.rs[1:0];
    alu_control_d = d.ac[2:0];
    rs1_d         = d.rs1[AW-1:0];
    rs2_d         = d.rs2[AW-1:0];
    rd_d          = d.rd[AW-1:0];
    zero_e        = z[0];
    reset         = r[0];

    redirect = ((in_e.br != 0 && z != 0) || in_e.jp != 0) ? 1 : 0;
    load_use = (in_e.rs == 1 && in_e.rd != 0 && (d.rs1 == in_e.rd || d.rs2 == in_e.rd)) ? 1 : 0;
    stall    = (load_use != 0 && redirect == 0) ? 1 : 0;

    e.alu_control_e = in_e.ac;
    e.alu_src_e     = in_e.as;
    e.fa            = producer(in_e.rs1);
    e.fb            = producer(in_e.rs2);
    e.pc_src        = redirect;
    e.rd_e          = in_e.rd;
    e.mem_write_m   = in_m.mw;
    e.rd_m          = in_m.rd;
    e.reg_write_w   = in_w.rw;
    e.result_src_w  = in_w.rs;
    e.rd_w          = in_w.rd;
    e.stall_f       = stall;
    e.stall_d       = stall;
    e.flush_d       = redirect;
    e.scnt          = m_scnt;
    e.fcnt          = m_fcnt;
    exp_q.push_back(e);

    last_stall = (stall != 0);
    if (r != 0) begin
      in_e = nop_i; in_m = nop_i; in_w = nop_i;
      m_scnt = 0; m_fcnt = 0;
    end else begin
      in_w = in_m;
      in_m = in_e;
      in_e = (load_use != 0 || redirect != 0) ? nop_i : d;
      if (stall != 0 && m_scnt < CntMax) m_scnt++;
      if (redirect != 0 && m_fcnt < CntMax) m_fcnt++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int rnd_reg();
    return ($urandom % 8 == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 3));
  endfunction

  function automatic instr_t rnd_instr();
    instr_t t;
    t.rw  = $urandom % 2;
    t.mw  = ($urandom % 4 == 0) ? 1 : 0;
    t.br  = ($urandom % 6 == 0) ? 1 : 0;
    t.jp  = ($urandom % 16 == 0) ? 1 : 0;
    t.as  = $urandom % 2;
    t.rs  = $urandom_range(0, 3);
    t.ac  = $urandom_range(0, 7);
    t.rs1 = rnd_reg();
    t.rs2 = rnd_reg();
    t.rd  = rnd_reg();
    return t;
  endfunction

  // Monitor: every cycle the DUT presents a full output vector.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("alu_control_e", 32'(alu_control_e), e.alu_control_e);
      chk("alu_src_e", 32'(alu_src_e), e.alu_src_e);
      chk("forward_a_e", 32'(forward_a_e), e.fa);
      chk("forward_b_e", 32'(forward_b_e), e.fb);
      chk("pc_src_e", 32'(pc_src_e), e.pc_src);
      chk("rd_e", 32'(rd_e), e.rd_e);
      chk("mem_write_m", 32'(mem_write_m), e.mem_write_m);
      chk("rd_m", 32'(rd_m), e.rd_m);
      chk("reg_write_w", 32'(reg_write_w), e.reg_write_w);
      chk("result_src_w", 32'(result_src_w), e.result_src_w);
      chk("rd_w", 32'(rd_w), e.rd_w);
      chk("stall_f", 32'(stall_f), e.stall_f);
      chk("stall_d", 32'(stall_d), e.stall_d);
      chk("flush_d", 32'(flush_d), e.flush_d);
      chk("stall_cnt", 32'(stall_cnt), e.scnt);
      chk("flush_cnt", 32'(flush_cnt), e.fcnt);
    end
  end

  initial begin
    instr_t a, b, lw, dep, cur;
    in_e = nop_i; in_m = nop_i; in_w = nop_i;
    m_scnt = 0; m_fcnt = 0; last_stall = 0;
    reset = 1'b1;
    {reg_write_d, mem_write_d, branch_d, jump_d, alu_src_d} = '0;
    result_src_d = '0; alu_control_d = '0;
    rs1_d = '0; rs2_d = '0; rd_d = '0; zero_e = 1'b0;
    tick(); tick();

    // Cycle after reset: everything zero.
    drive(nop_i, 1, 0);
    @(negedge clk);
    chk("post_reset_pc_src", 32'(pc_src_e), 0);
    chk("post_reset_stall_cnt", 32'(stall_cnt), 0);
    tick();

    // Forward from M to rs1 only.
    a = nop_i; a.rw = 1; a.rd = 5;
    b = nop_i; b.rs1 = 5; b.rs2 = 7;
    drive(a, 0, 0); tick();
    drive(b, 0, 0); tick();
    drive(nop_i, 0, 0);
    @(negedge clk);
    chk("fwd_m_a", 32'(forward_a_e), 2);
    chk("fwd_m_b", 32'(forward_b_e), 0);
    tick();

    // x0 is never forwarded, and a load to x0 never stalls.
    a = nop_i; a.rw = 1; a.rd = 0;
    b = nop_i; b.rs1 = 0;
    drive(a, 0, 0); tick();
    drive(b, 0, 0); tick();
    drive(nop_i, 0, 0);
    @(negedge clk);
    chk("x0_fwd_a", 32'(forward_a_e), 0);
    tick();
    lw = nop_i; lw.rw = 1; lw.rs = 1; lw.rd = 0;
    dep = nop_i; dep.rs1 = 0;
    drive(lw, 0, 0); tick();
    drive(dep, 0, 0);
    @(negedge clk);
    chk("x0_lw_stall_d", 32'(stall_d), 0);
    tick();

    // Load-use: one stall cycle, then W forwarding.
    drive(nop_i, 0, 1); tick();
    lw = nop_i; lw.rw = 1; lw.rs = 1; lw.rd = 6;
    dep = nop_i; dep.rs2 = 6; dep.rw = 1; dep.rd = 9;
    drive(lw, 0, 0); tick();
    drive(dep, 0, 0);
    @(negedge clk);
    chk("lu_stall_f", 32'(stall_f), 1);
    chk("lu_stall_d", 32'(stall_d), 1);
    tick();
    drive(dep, 0, 0);
    @(negedge clk);
    chk("lu_bubble_rd_e", 32'(rd_e), 0);
    chk("lu_one_cycle", 32'(stall_d), 0);
    chk("lu_stall_cnt", 32'(stall_cnt), 1);
    tick();
    drive(nop_i, 0, 0);
    @(negedge clk);
    chk("lu_fwd_b", 32'(forward_b_e), 1);
    chk("lu_dep_rd_e", 32'(rd_e), 9);
    tick();

    // Taken branch flushes decode.
    drive(nop_i, 0, 1); tick();
    a = nop_i; a.br = 1; a.ac = 5; a.rd = 3;
    b = nop_i; b.ac = 7; b.rd = 4; b.rw = 1;
    drive(a, 0, 0); tick();
    drive(b, 1, 0);
    @(negedge clk);
    chk("br_pc_src", 32'(pc_src_e), 1);
    chk("br_flush_d", 32'(flush_d), 1);
    tick();
    drive(nop_i, 0, 0);
    @(negedge clk);
    chk("br_bubble_alu", 32'(alu_control_e), 0);
    chk("br_bubble_rd", 32'(rd_e), 0);
    chk("br_flush_cnt", 32'(flush_cnt), 1);
    tick();

    // Load-use condition together with a jump: redirect wins.
    drive(nop_i, 0, 1); tick();
    a = nop_i; a.jp = 1; a.rs = 1; a.rw = 1; a.rd = 6;
    dep = nop_i; dep.rs1 = 6;
    drive(a, 0, 0); tick();
    drive(dep, 0, 0);
    @(negedge clk);
    chk("jlu_pc_src", 32'(pc_src_e), 1);
    chk("jlu_stall_f", 32'(stall_f), 0);
    chk("jlu_flush_d", 32'(flush_d), 1);
    tick();

    // Reset during an active stall.
    drive(nop_i, 0, 1); tick();
    lw = nop_i; lw.rw = 1; lw.rs = 1; lw.rd = 6;
    dep = nop_i; dep.rs2 = 6;
    drive(lw, 0, 0); tick();
    drive(dep, 0, 1);
    @(negedge clk);
    chk("rst_mid_stall_d", 32'(stall_d), 1);
    tick();
    drive(dep, 0, 0);
    @(negedge clk);
    chk("rst_after_stall_d", 32'(stall_d), 0);
    chk("rst_after_scnt", 32'(stall_cnt), 0);
    chk("rst_after_rd_e", 32'(rd_e), 0);
    tick();

    // Flush counter saturation.
    drive(nop_i, 0, 1); tick();
    a = nop_i; a.jp = 1;
    for (int i = 0; i < 40; i++) begin
      drive(a, 0, 0); tick();
    end
    drive(nop_i, 0, 0);
    @(negedge clk);
    chk("flush_cnt_sat", 32'(flush_cnt), CntMax);
    tick();

    // Randomised traffic; a stalled decode instruction is re-presented.
    drive(nop_i, 0, 1); tick();
    last_stall = 0;
    cur = nop_i;
    for (int i = 0; i < 800; i++) begin
      if (!last_stall) cur = rnd_instr();
      drive(cur, int'($urandom % 2), ($urandom % 100 == 0) ? 1 : 0);
      tick();
    end

    @(negedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_control.md
PIPELINE_CONTROL -- requirements
Module: pipeline_control

Interface
REQ-001 Parameter: REG_ADDR_W, default 5, register-index width.
REQ-002 Parameter: CNT_W, default 16, stall/flush counter width.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; reset  in  1  synchronous active-high reset.
REQ-004 Decode-stage inputs SHALL be: reg_write_d, mem_write_d, branch_d, jump_d, alu_src_d (in, 1 each); result_src_d (in, 2); alu_control_d (in, 3); rs1_d, rs2_d, rd_d (in, REG_ADDR_W).
REQ-005 Execute-stage input SHALL be: zero_e  in  1  ALU zero flag.
REQ-006 Execute-stage outputs SHALL be: alu_control_e (out, 3); alu_src_e (out, 1); forward_a_e, forward_b_e (out, 2); pc_src_e (out, 1); rd_e (out, REG_ADDR_W).
REQ-007 Memory-stage outputs SHALL be: mem_write_m (out, 1); rd_m (out, REG_ADDR_W).
REQ-008 Writeback-stage outputs SHALL be: reg_write_w (out, 1); result_src_w (out, 2); rd_w (out, REG_ADDR_W).
REQ-009 Hazard outputs SHALL be: stall_f, stall_d, flush_d (out, 1 each).
REQ-010 Counter outputs SHALL be: stall_cnt, flush_cnt (out, CNT_W).

Function
REQ-011 The block SHALL hold three control register stages (D->E, E->M, M->W), each advancing every clk edge.
REQ-012 D->E SHALL capture all decode controls plus rs1_d, rs2_d and rd_d; E->M SHALL carry reg_write, mem_write, result_src and rd; M->W SHALL carry reg_write, result_src and rd.
REQ-013 A bubble SHALL set every control field, including rd, to zero.
REQ-014 Forwarding SHALL be combinational and defined on forward_a_e (rs1_e) and forward_b_e (rs2_e), each forward_x_e evaluated on its own source register.
REQ-015 Forwarding: forward_x_e = 2'b10 when reg_write_m and rd_m!=0 and rd_m==rs_x_e.
REQ-016 Otherwise forward_x_e = 2'b01 when reg_write_w and rd_w!=0 and rd_w==rs_x_e; otherwise forward_x_e = 2'b00; the M-stage match SHALL win over the W-stage match.
REQ-017 lw_stall SHALL be asserted when result_src_e==2'b01 and rd_e!=0 and (rs1_d==rd_e or rs2_d==rd_e).
REQ-018 pc_src_e SHALL equal (branch_e AND zero_e) OR jump_e, combinationally.
REQ-019 stall_f = stall_d = lw_stall AND NOT pc_src_e; a redirect SHALL override the stall so the PC loads the target.
REQ-020 flush_d SHALL equal pc_src_e.
REQ-021 The D->E register SHALL load a bubble when lw_stall or pc_src_e is asserted; otherwise it SHALL load the decode inputs.
REQ-022 The E->M and M->W registers SHALL never stall or flush.
REQ-023 A load-use stall SHALL last exactly one cycle; the dependent instruction SHALL then receive forward_x_e=2'b01.
REQ-024 stall_cnt SHALL increment on each cycle with stall_d=1, saturating at all-ones.
REQ-025 flush_cnt SHALL increment on each cycle with flush_d=1, saturating at all-ones.
REQ-026 Illegal or X control inputs are the decoder's concern; the block SHALL pass them unchanged except when it inserts a bubble.

Reset
REQ-027 On reset, all three stage registers SHALL become bubbles and stall_cnt and flush_cnt SHALL become 0.
REQ-028 In the cycle after reset, every output SHALL be 0.
REQ-029 Reset SHALL take priority over stall, flush and counting, including reset asserted mid-stall or mid-flush.

Structure
REQ-030 A package riscv_ctrl_pkg SHALL hold the result_src encodings (ALU=00, MEM=01, PC4=10), alu_control codes, forward-select codes (NONE=00, WB=01, MEM=10) and the bubble constant.
REQ-031 Forwarding and lw_stall/pc_src logic SHALL live in one combinational sub-module, hazard_unit; the stage registers and counters SHALL live in pipeline_control.

Verification
REQ-032 Forward from M: reg_write_m=1, rd_m=5, rs1_e=5 -> forward_a_e=10, forward_b_e=00.
REQ-033 Load-use stall: lw rd_e=6 (result_src_e=01), rs2_d=6 -> stall_f=stall_d=1 for one cycle and a bubble in E; next cycle forward_b_e=01, stall_cnt=1.
REQ-034 Taken branch: branch_e=1, zero_e=1 -> pc_src_e=1, flush_d=1; next cycle all E controls are 0 and flush_cnt=1.
REQ-035 x0 destination: rd_m=0, reg_write_m=1, rs1_e=0 -> forward_a_e=00; a lw with rd_e=0 -> no stall.
REQ-036 Simultaneous events: lw_stall condition true while jump_e=1 -> pc_src_e=1, stall_f=0, flush_d=1.
REQ-037 Reset mid-stall: reset=1 during an active lw_stall -> next cycle all outputs 0 and counters 0; normal operation resumes after reset deasserts.
